// File: rtl/arbitro_display_bcd.sv
// rtl/arbitro_display_bcd.sv - arbitrates two requesters onto a 4-digit BCD display
// Grants A or B, converts the captured value by sequential double-dabble, then holds it on screen.
module arbitro_display_bcd #(
    parameter int HOLD_CYCLES = 25000000,
    parameter bit PRIO_B      = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic [13:0] val_a,
    input  logic        req_b,
    input  logic [13:0] val_b,
    output logic        ack_a,
    output logic        ack_b,
    output logic [3:0]  unidades,
    output logic [3:0]  decenas,
    output logic [3:0]  centenas,
    output logic [3:0]  unidadesMillar,
    output logic        ovf,
    output logic        busy
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [13:0]   bin_sr;
    logic [13:0]   val_cap;
    logic [15:0]   bcd_sr;
    logic [15:0]   bcd_adj;
    logic [3:0]    count;
    logic [HW-1:0] hold_cnt;
    logic          last_b;
    logic          sel_b;

    // With both pending the side that was not served last wins, giving strict alternation.
    always_comb begin
        sel_b = 1'b0;
        if (req_a && req_b) begin
            sel_b = !last_b;
        end else begin
            sel_b = req_b;
        end
    end

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < 4; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_a || req_b) state_next = SHIFT;
            SHIFT:   if (count == 4'd13) state_next = DONE;
            DONE:    state_next = HOLD;
            HOLD:    if (hold_cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_sr         <= '0;
            val_cap        <= '0;
            bcd_sr         <= '0;
            count          <= '0;
            hold_cnt       <= '0;
            // Reset marks the non-preferred side as last served so the preferred side wins first.
            last_b         <= !PRIO_B;
            ack_a          <= 1'b0;
            ack_b          <= 1'b0;
            unidades       <= '0;
            decenas        <= '0;
            centenas       <= '0;
            unidadesMillar <= '0;
            ovf            <= 1'b0;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        bin_sr  <= sel_b ? val_b : val_a;
                        val_cap <= sel_b ? val_b : val_a;
                        bcd_sr  <= '0;
                        count   <= '0;
                        last_b  <= sel_b;
                    end
                end
                SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj[14:0], bin_sr, 1'b0};
                    count            <= count + 4'd1;
                end
                DONE: begin
                    if (val_cap > 14'd9999) begin
                        {unidadesMillar, centenas, decenas, unidades} <= 16'hEEEE;
                        ovf <= 1'b1;
                    end else begin
                        {unidadesMillar, centenas, decenas, unidades} <= bcd_sr;
                        ovf <= 1'b0;
                    end
                    ack_a    <= !last_b;
                    ack_b    <= last_b;
                    hold_cnt <= HW'(HOLD_CYCLES - 1);
                end
                HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
